// File: rtl/csr_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_if
//  Description : CSR access, exception commit, interrupt line and redirect
//                bundle between the writeback stage and the CSR file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_if;
   // CSR read/write port
   logic        csr_re;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;

   // Exception / return commit from writeback
   logic        wb_ex;
   logic        ertn_flush;
   logic [31:0] wb_pc;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_vaddr;

   // Level-sensitive interrupt lines
   logic [7:0]  hw_int_in;
   logic        ipi_int_in;

   // Results towards the pipeline
   logic        has_int;
   logic [31:0] ex_entry;
   logic [31:0] ertn_entry;

   // Pipeline side: issues accesses and commits, consumes redirects
   modport master (
      output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
      output wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
      output hw_int_in, ipi_int_in,
      input  csr_rvalue, has_int, ex_entry, ertn_entry
   );

   // CSR file side
   modport slave (
      input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
      input  wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
      input  hw_int_in, ipi_int_in,
      output csr_rvalue, has_int, ex_entry, ertn_entry
   );
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
//  Module      : csr_file
//  Description : LoongArch control/status register file. Combinational reads,
//                masked writes, exception entry/return state, stable-counter
//                timer and interrupt pending/enable evaluation.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_file #(
   parameter logic [31:0] TID_RESET = 32'h0
) (
   input  logic   clk,
   input  logic   resetn,
   csr_if.slave   bus
);

   // CSR addresses
   localparam logic [13:0] c_CSR_CRMD   = 14'h000;
   localparam logic [13:0] c_CSR_PRMD   = 14'h001;
   localparam logic [13:0] c_CSR_ECFG   = 14'h004;
   localparam logic [13:0] c_CSR_ESTAT  = 14'h005;
   localparam logic [13:0] c_CSR_ERA    = 14'h006;
   localparam logic [13:0] c_CSR_BADV   = 14'h007;
   localparam logic [13:0] c_CSR_EENTRY = 14'h00c;
   localparam logic [13:0] c_CSR_SAVE0  = 14'h030;
   localparam logic [13:0] c_CSR_TID    = 14'h040;
   localparam logic [13:0] c_CSR_TCFG   = 14'h041;
   localparam logic [13:0] c_CSR_TVAL   = 14'h042;
   localparam logic [13:0] c_CSR_TICLR  = 14'h044;

   localparam logic [5:0]  c_ECODE_ADE  = 6'h08;
   localparam logic [5:0]  c_ECODE_ALE  = 6'h09;
   localparam logic [12:0] c_LIE_MASK   = 13'h1bff;
   localparam logic [31:0] c_CNT_IDLE   = 32'hffff_ffff;

   // ------------------------------------------------------------------------
   // Architectural state
   // ------------------------------------------------------------------------
   logic [1:0]  r_crmd_plv;
   logic        r_crmd_ie;
   logic [1:0]  r_prmd_pplv;
   logic        r_prmd_pie;
   logic [12:0] r_ecfg_lie;
   logic [1:0]  r_estat_is_sw;
   logic [7:0]  r_estat_is_hw;
   logic        r_estat_ti;
   logic        r_estat_ipi;
   logic [5:0]  r_estat_ecode;
   logic [8:0]  r_estat_esubcode;
   logic [31:0] r_era;
   logic [31:0] r_badv;
   logic [25:0] r_eentry_va;
   logic [31:0] r_save [0:3];
   logic [31:0] r_tid;
   logic        r_tcfg_en;
   logic        r_tcfg_periodic;
   logic [29:0] r_tcfg_initval;
   logic [31:0] r_timer_cnt;

   // csr_re is informational only: the read path is always live
   logic w_unused_csr_re;
   assign w_unused_csr_re = bus.csr_re;

   // ------------------------------------------------------------------------
   // Architectural read views of each register
   // ------------------------------------------------------------------------
   logic [31:0] w_crmd;
   logic [31:0] w_prmd;
   logic [31:0] w_ecfg;
   logic [12:0] w_estat_is;
   logic [31:0] w_estat;
   logic [31:0] w_eentry;
   logic [31:0] w_tcfg;

   assign w_crmd     = {28'b0, 1'b1, r_crmd_ie, r_crmd_plv};
   assign w_prmd     = {29'b0, r_prmd_pie, r_prmd_pplv};
   assign w_ecfg     = {19'b0, r_ecfg_lie};
   assign w_estat_is = {r_estat_ipi, r_estat_ti, 1'b0, r_estat_is_hw, r_estat_is_sw};
   assign w_estat    = {1'b0, r_estat_esubcode, r_estat_ecode, 3'b0, w_estat_is};
   assign w_eentry   = {r_eentry_va, 6'b0};
   assign w_tcfg     = {r_tcfg_initval, r_tcfg_periodic, r_tcfg_en};

   // ------------------------------------------------------------------------
   // Write decode and masked merge
   // ------------------------------------------------------------------------
   function automatic logic [31:0] merge(input logic [31:0] old_val,
                                         input logic [31:0] wmask,
                                         input logic [31:0] wvalue);
      return (old_val & ~wmask) | (wvalue & wmask);
   endfunction

   logic w_wr_crmd, w_wr_prmd, w_wr_ecfg, w_wr_estat, w_wr_era, w_wr_badv;
   logic w_wr_eentry, w_wr_tid, w_wr_tcfg, w_wr_ticlr;

   assign w_wr_crmd   = bus.csr_we && (bus.csr_num == c_CSR_CRMD);
   assign w_wr_prmd   = bus.csr_we && (bus.csr_num == c_CSR_PRMD);
   assign w_wr_ecfg   = bus.csr_we && (bus.csr_num == c_CSR_ECFG);
   assign w_wr_estat  = bus.csr_we && (bus.csr_num == c_CSR_ESTAT);
   assign w_wr_era    = bus.csr_we && (bus.csr_num == c_CSR_ERA);
   assign w_wr_badv   = bus.csr_we && (bus.csr_num == c_CSR_BADV);
   assign w_wr_eentry = bus.csr_we && (bus.csr_num == c_CSR_EENTRY);
   assign w_wr_tid    = bus.csr_we && (bus.csr_num == c_CSR_TID);
   assign w_wr_tcfg   = bus.csr_we && (bus.csr_num == c_CSR_TCFG);
   assign w_wr_ticlr  = bus.csr_we && (bus.csr_num == c_CSR_TICLR);

   logic [31:0] w_crmd_new, w_prmd_new, w_ecfg_new, w_estat_new;
   logic [31:0] w_era_new, w_badv_new, w_eentry_new, w_tid_new, w_tcfg_new;

   assign w_crmd_new   = merge(w_crmd,   bus.csr_wmask, bus.csr_wvalue);
   assign w_prmd_new   = merge(w_prmd,   bus.csr_wmask, bus.csr_wvalue);
   assign w_ecfg_new   = merge(w_ecfg,   bus.csr_wmask, bus.csr_wvalue);
   assign w_estat_new  = merge(w_estat,  bus.csr_wmask, bus.csr_wvalue);
   assign w_era_new    = merge(r_era,    bus.csr_wmask, bus.csr_wvalue);
   assign w_badv_new   = merge(r_badv,   bus.csr_wmask, bus.csr_wvalue);
   assign w_eentry_new = merge(w_eentry, bus.csr_wmask, bus.csr_wvalue);
   assign w_tid_new    = merge(r_tid,    bus.csr_wmask, bus.csr_wvalue);
   assign w_tcfg_new   = merge(w_tcfg,   bus.csr_wmask, bus.csr_wvalue);

   // BADV captures the faulting address only for address-error exceptions
   logic w_ex_badv;
   assign w_ex_badv = bus.wb_ex &&
                      ((bus.wb_ecode == c_ECODE_ADE) || (bus.wb_ecode == c_ECODE_ALE));

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------

   // CRMD/PRMD: exception saves and clears the mode, ertn restores it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_crmd_plv  <= 2'b00;
         r_crmd_ie   <= 1'b0;
         r_prmd_pplv <= 2'b00;
         r_prmd_pie  <= 1'b0;
      end else begin
         if (bus.wb_ex) begin
            r_crmd_plv <= 2'b00;
            r_crmd_ie  <= 1'b0;
         end else if (bus.ertn_flush) begin
            r_crmd_plv <= r_prmd_pplv;
            r_crmd_ie  <= r_prmd_pie;
         end else if (w_wr_crmd) begin
            r_crmd_plv <= w_crmd_new[1:0];
            r_crmd_ie  <= w_crmd_new[2];
         end

         if (bus.wb_ex) begin
            r_prmd_pplv <= r_crmd_plv;
            r_prmd_pie  <= r_crmd_ie;
         end else if (w_wr_prmd) begin
            r_prmd_pplv <= w_prmd_new[1:0];
            r_prmd_pie  <= w_prmd_new[2];
         end
      end
   end

   // ECFG local interrupt enables; bit 10 has no source and stays 0
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ecfg_lie <= 13'b0;
      end else if (w_wr_ecfg) begin
         r_ecfg_lie <= w_ecfg_new[12:0] & c_LIE_MASK;
      end
   end

   // ESTAT: sampled interrupt lines, software IS bits and exception cause
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_estat_is_sw    <= 2'b00;
         r_estat_is_hw    <= 8'b0;
         r_estat_ipi      <= 1'b0;
         r_estat_ecode    <= 6'b0;
         r_estat_esubcode <= 9'b0;
      end else begin
         r_estat_is_hw <= bus.hw_int_in;
         r_estat_ipi   <= bus.ipi_int_in;
         if (w_wr_estat) begin
            r_estat_is_sw <= w_estat_new[1:0];
         end
         if (bus.wb_ex) begin
            r_estat_ecode    <= bus.wb_ecode;
            r_estat_esubcode <= bus.wb_esubcode;
         end
      end
   end

   // ERA/BADV: exception capture takes priority over software writes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_era  <= 32'b0;
         r_badv <= 32'b0;
      end else begin
         if (bus.wb_ex) begin
            r_era <= bus.wb_pc;
         end else if (w_wr_era) begin
            r_era <= w_era_new;
         end

         if (w_ex_badv) begin
            r_badv <= bus.wb_vaddr;
         end else if (w_wr_badv) begin
            r_badv <= w_badv_new;
         end
      end
   end

   // EENTRY, TID and TCFG are plain software-written registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_eentry_va     <= 26'b0;
         r_tid           <= TID_RESET;
         r_tcfg_en       <= 1'b0;
         r_tcfg_periodic <= 1'b0;
         r_tcfg_initval  <= 30'b0;
      end else begin
         if (w_wr_eentry) begin
            r_eentry_va <= w_eentry_new[31:6];
         end
         if (w_wr_tid) begin
            r_tid <= w_tid_new;
         end
         if (w_wr_tcfg) begin
            r_tcfg_en       <= w_tcfg_new[0];
            r_tcfg_periodic <= w_tcfg_new[1];
            r_tcfg_initval  <= w_tcfg_new[31:2];
         end
      end
   end

   // SAVE0-3 scratch registers
   generate
      for (genvar g = 0; g < 4; g++) begin : g_save
         logic w_wr_save;
         assign w_wr_save = bus.csr_we && (bus.csr_num == (c_CSR_SAVE0 + 14'(g)));

         // One fully writable scratch register
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               r_save[g] <= 32'b0;
            end else if (w_wr_save) begin
               r_save[g] <= merge(r_save[g], bus.csr_wmask, bus.csr_wvalue);
            end
         end
      end
   endgenerate

   // Stable counter: load on enabling write, then count down; one-shot mode
   // parks at all-ones after passing zero, periodic mode reloads at zero
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_timer_cnt <= c_CNT_IDLE;
      end else if (w_wr_tcfg && w_tcfg_new[0]) begin
         r_timer_cnt <= {w_tcfg_new[31:2], 2'b00};
      end else if (r_tcfg_en && (r_timer_cnt != c_CNT_IDLE)) begin
         if ((r_timer_cnt == 32'b0) && r_tcfg_periodic) begin
            r_timer_cnt <= {r_tcfg_initval, 2'b00};
         end else begin
            r_timer_cnt <= r_timer_cnt - 32'd1;
         end
      end
   end

   // Timer pending bit: a timeout in the same cycle as a clear keeps it set
   logic w_timer_fire;
   logic w_ticlr;
   assign w_timer_fire = r_tcfg_en && (r_timer_cnt == 32'b0);
   assign w_ticlr      = w_wr_ticlr && bus.csr_wvalue[0] && bus.csr_wmask[0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_estat_ti <= 1'b0;
      end else if (w_timer_fire) begin
         r_estat_ti <= 1'b1;
      end else if (w_ticlr) begin
         r_estat_ti <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------

   // Combinational read mux; unmapped addresses and TICLR read zero
   always_comb begin
      bus.csr_rvalue = 32'b0;
      case (bus.csr_num)
         c_CSR_CRMD:          bus.csr_rvalue = w_crmd;
         c_CSR_PRMD:          bus.csr_rvalue = w_prmd;
         c_CSR_ECFG:          bus.csr_rvalue = w_ecfg;
         c_CSR_ESTAT:         bus.csr_rvalue = w_estat;
         c_CSR_ERA:           bus.csr_rvalue = r_era;
         c_CSR_BADV:          bus.csr_rvalue = r_badv;
         c_CSR_EENTRY:        bus.csr_rvalue = w_eentry;
         c_CSR_SAVE0:         bus.csr_rvalue = r_save[0];
         c_CSR_SAVE0 + 14'd1: bus.csr_rvalue = r_save[1];
         c_CSR_SAVE0 + 14'd2: bus.csr_rvalue = r_save[2];
         c_CSR_SAVE0 + 14'd3: bus.csr_rvalue = r_save[3];
         c_CSR_TID:           bus.csr_rvalue = r_tid;
         c_CSR_TCFG:          bus.csr_rvalue = w_tcfg;
         c_CSR_TVAL:          bus.csr_rvalue = r_timer_cnt;
         default:             bus.csr_rvalue = 32'b0;
      endcase
   end

   assign bus.has_int    = r_crmd_ie && (|(w_estat_is & r_ecfg_lie));
   assign bus.ex_entry   = w_eentry;
   assign bus.ertn_entry = r_era;

endmodule
`default_nettype wire

// File: doc/csr_file.md
Name: csr_file

Overview:
- Control/status register file for the LoongArch pipeline; the counterpart of the writeback stage's CSR and exception interface.
- Serves combinational CSR reads and commits masked CSR writes.
- Records exception state on wb_ex and restores it on ertn_flush.
- Owns the stable-counter timer and interrupt pending/enable logic.
- Drives exception and return redirect targets to the fetch stage.

Parameters:
TID_RESET, 32'h0, reset value of TID (core id)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
csr_re  in  1  read enable (informational; read path is always live)
csr_num  in  14  CSR address for read and write
csr_rvalue  out  32  combinational read data for csr_num
csr_we  in  1  write enable, commits at posedge
csr_wmask  in  32  per-bit write mask
csr_wvalue  in  32  write data
wb_ex  in  1  exception commit from writeback
ertn_flush  in  1  ertn commit from writeback
wb_pc  in  32  pc of the excepting instruction
wb_ecode  in  6  exception code
wb_esubcode  in  9  exception subcode
wb_vaddr  in  32  faulting address for ADE/ALE
hw_int_in  in  8  hardware interrupt lines, level-sensitive
ipi_int_in  in  1  inter-processor interrupt, level-sensitive
has_int  out  1  interrupt pending and enabled
ex_entry  out  32  exception target (= EENTRY)
ertn_entry  out  32  return target (= ERA)

Behaviour:
- Write rule: new = (old & ~wmask) | (wvalue & wmask), applied only to writable fields.
- Reads are combinational and return pre-edge values. Unmapped addresses read 0.
- CRMD 0x0, reset 32'h8.
  - PLV[1:0] and IE[2] are writable. DA[3] is fixed at 1. All other bits read 0.
  - wb_ex: PLV<=0, IE<=0.
  - ertn_flush: PLV<=PRMD.PPLV, IE<=PRMD.PIE.
- PRMD 0x1, reset 0. PPLV[1:0] and PIE[2] are writable.
  - wb_ex: PPLV<=CRMD.PLV, PIE<=CRMD.IE.
- ECFG 0x4, reset 0. LIE[12:0] is writable except bit 10 (writable mask 0x1bff).
- ESTAT 0x5, reset 0.
  - IS[1:0] are software-writable.
  - IS[9:2]<=hw_int_in every cycle. IS[10]=0. IS[12]<=ipi_int_in every cycle.
  - IS[11] is the timer pending bit.
  - Ecode[21:16] and EsubCode[30:22] load from wb_ecode/wb_esubcode on wb_ex and are otherwise read-only.
- ERA 0x6, reset 0. wb_ex: ERA<=wb_pc; otherwise fully writable.
- BADV 0x7, reset 0.
  - wb_ex with ecode 0x08 (ADE) or 0x09 (ALE): BADV<=wb_vaddr.
  - Otherwise fully writable.
- EENTRY 0xc, reset 0. VA[31:6] writable, [5:0] read 0.
- SAVE0-3 0x30-0x33, reset 0, fully writable.
- TID 0x40, reset TID_RESET, fully writable.
- TCFG 0x41, reset 0. En[0], Periodic[1], InitVal[31:2] are all writable.
- TVAL 0x42 is read-only and returns timer_cnt.
  - timer_cnt reset value is 32'hffffffff.
  - TCFG write whose new En=1: timer_cnt <= {new InitVal,2'b00}.
  - Else, when En=1 and timer_cnt!=32'hffffffff:
    - timer_cnt==0 and Periodic=1: reload {InitVal,2'b00}.
    - Otherwise: decrement.
  - The counter stops at 32'hffffffff in one-shot mode.
- Timer pending bit IS[11]:
  - Set on the cycle after timer_cnt==0 && En=1.
  - Cleared by a TICLR write with wvalue[0]&wmask[0]=1.
  - Set wins when set and clear coincide.
- TICLR 0x44 always reads 0.
- Priority per field: wb_ex > ertn_flush > csr_we.
  - wb_ex and ertn_flush together is illegal; wb_ex wins.
  - csr_we in the same cycle as wb_ex is ignored for every field wb_ex updates.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]); combinational.
- ex_entry = EENTRY; ertn_entry = ERA; both combinational.
- Reset asserted mid-operation:
  - All registers and timer_cnt take their reset values immediately (asynchronous).
  - Outputs follow combinationally: has_int=0, ex_entry=0, ertn_entry=0, csr_rvalue reflects reset contents.

Test Plan:
1. Reset, then read 0x0 -> 32'h8. Read 0x40 -> TID_RESET. Read 0x42 -> 32'hffffffff. Read 0x99 -> 0.
2. Write CRMD wvalue 32'h7, wmask 32'h7 -> CRMD=32'hf. Then wb_ex, pc 32'h1c00_0100, ecode 0x0b -> CRMD=32'h8, PRMD=32'h7, ERA=32'h1c00_0100, ESTAT[21:16]=0x0b. Then ertn_flush -> CRMD=32'hf, ertn_entry=32'h1c00_0100.
3. wb_ex with ecode 0x09, vaddr 32'h1234_5679 -> BADV=32'h1234_5679. Repeat with ecode 0x0b -> BADV unchanged.
4. Write TCFG=32'h11 (InitVal 4, one-shot, En=1) -> TVAL runs 16..0 then 32'hffffffff and holds; IS[11] set once. With ECFG=32'h800 and CRMD.IE=1 -> has_int=1. TICLR write 1 -> IS[11]=0, has_int=0.
5. TCFG=32'hb (InitVal 2, periodic) -> TVAL reloads 8 after 0 and IS[11] re-asserts every 9 cycles. A TICLR write in the cycle IS[11] sets -> IS[11] stays 1.
6. Same-cycle csr_we to ERA (value 32'hdead_beef) with wb_ex -> ERA=wb_pc. Deassert resetn mid-timer-countdown -> TVAL=32'hffffffff and has_int=0 with no clock edge.
